// File: rtl/seg7_pkg.sv
// seg7_display_ctrl shared definitions:
// register map, CTRL fields and hex decode.
package seg7_pkg;

  localparam logic [2:0] A_DIGITS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_RAW_LO = 3'd2;
  localparam logic [2:0] A_RAW_HI = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLANK = 8;
  localparam int CTRL_BLINK = 16;
  localparam int CTRL_RAW   = 24;
  localparam int STAT_PHASE = 8;

  // gfedcba, segment lit = 1
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_seg(
    input logic [3:0] v
  );
    return HEX_TAB[v];
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Avalon-MM slave port bundle for the
// 7-segment display controller.
interface seg7_display_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/seg7_tick_gen.sv
// Free-running divider: counts 0..DIV-1
// and pulses tick while at DIV-1.
module seg7_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller with
// static and scanned outputs.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seg7_display_ctrl_if.slave      bus,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_an
);

  localparam logic INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_RST =
    {NUM_DIGITS{INV}} ^ NUM_DIGITS'(1);

  logic [3:0] digits_q [NUM_DIGITS];
  logic [6:0] raw_q    [NUM_DIGITS];
  logic [6:0] pat      [NUM_DIGITS];

  logic                  en_q;
  logic [NUM_DIGITS-1:0] blank_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [NUM_DIGITS-1:0] rawm_q;
  logic [2:0]            idx_q;
  logic                  phase_q;
  logic                  scan_tick;
  logic                  blink_tick;
  logic                  wr;
  logic [31:0]           rd;
  logic [6:0]            sel_pat;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  unused_wd;

  assign wr        = bus.chipselect && !bus.write_n;
  assign unused_wd = ^bus.writedata;

  seg7_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (scan_tick)
  );

  seg7_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (blink_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      blank_q <= '0;
      blink_q <= '0;
      rawm_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_q[i] <= '0;
        raw_q[i]    <= '0;
      end
    end else if (wr) begin
      if (bus.address == A_DIGITS)
        for (int i = 0; i < NUM_DIGITS; i++)
          digits_q[i] <= bus.writedata[4*i +: 4];
      if (bus.address == A_CTRL) begin
        en_q <= bus.writedata[CTRL_EN];
        for (int i = 0; i < NUM_DIGITS; i++) begin
          blank_q[i] <= bus.writedata[CTRL_BLANK+i];
          blink_q[i] <= bus.writedata[CTRL_BLINK+i];
          rawm_q[i]  <= bus.writedata[CTRL_RAW+i];
        end
      end
      // digits 0-3 live in RAW_LO, 4-7 in RAW_HI
      for (int i = 0; i < NUM_DIGITS; i++)
        if (bus.address == ((i < 4) ? A_RAW_LO : A_RAW_HI))
          raw_q[i] <= bus.writedata[8*(i%4) +: 7];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (scan_tick)
        idx_q <= (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
      if (blink_tick)
        phase_q <= ~phase_q;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      A_DIGITS:
        for (int i = 0; i < NUM_DIGITS; i++)
          rd[4*i +: 4] = digits_q[i];
      A_CTRL: begin
        rd[CTRL_EN] = en_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          rd[CTRL_BLANK+i] = blank_q[i];
          rd[CTRL_BLINK+i] = blink_q[i];
          rd[CTRL_RAW+i]   = rawm_q[i];
        end
      end
      A_RAW_LO:
        for (int i = 0; i < NUM_DIGITS; i++)
          if (i < 4)
            rd[8*(i%4) +: 7] = raw_q[i];
      A_RAW_HI:
        for (int i = 0; i < NUM_DIGITS; i++)
          if (i >= 4)
            rd[8*(i%4) +: 7] = raw_q[i];
      A_STATUS: begin
        rd[2:0]        = idx_q;
        rd[STAT_PHASE] = phase_q;
      end
      default: rd = '0;
    endcase
  end

  assign bus.readdata = rd;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pat[i] = '0;
      if (en_q && !blank_q[i] &&
          !(blink_q[i] && phase_q))
        pat[i] = rawm_q[i] ? raw_q[i]
                           : hex_seg(digits_q[i]);
    end
  end

  always_comb begin
    sel_pat = '0;
    an_nxt  = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == 3'(i)) begin
        sel_pat   = pat[i];
        an_nxt[i] = 1'b1;
      end
  end

  // scan_seg and scan_an share one register stage
  // so they always switch together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out  <= {7*NUM_DIGITS{INV}};
      scan_seg <= {7{INV}};
      scan_an  <= AN_RST;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        seg_out[7*i +: 7] <= pat[i] ^ {7{INV}};
      scan_seg <= sel_pat ^ {7{INV}};
      scan_an  <= an_nxt ^ {NUM_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl
// (6 digits, active-low, fast dividers).
module tb_seg7_display_ctrl;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BD = 8;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg7_display_ctrl_if bus();

  logic [7*ND-1:0] seg_out;
  logic [6:0]      scan_seg;
  logic [ND-1:0]   scan_an;

  seg7_display_ctrl #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .BLINK_DIV      (BD),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .seg_out  (seg_out),
    .scan_seg (scan_seg),
    .scan_an  (scan_an)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Spec-level model: software-visible registers plus
  // elapsed cycles since reset release (k).
  logic [3:0]    m_dig  [ND];
  logic [6:0]    m_rawb [ND];
  logic          m_en;
  logic [ND-1:0] m_blank, m_blink, m_raw;
  int            k;
  logic [7*ND-1:0] e_seg;
  logic [6:0]      e_scan;
  logic [ND-1:0]   e_an;

  function automatic logic [6:0] dig_pat(int i, int kk);
    if (!m_en || m_blank[i]) return 7'h00;
    if (m_blink[i] && ((kk / BD) % 2 == 1)) return 7'h00;
    if (m_raw[i]) return m_rawb[i];
    return HEX[m_dig[i]];
  endfunction

  function automatic logic [7*ND-1:0] all_seg(int kk);
    logic [7*ND-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = ~dig_pat(i, kk);
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k       <= 0;
      m_en    <= 1'b0;
      m_blank <= '0;
      m_blink <= '0;
      m_raw   <= '0;
      e_seg   <= '1;
      e_scan  <= 7'h7F;
      e_an    <= 6'b111110;
      for (int i = 0; i < ND; i++) begin
        m_dig[i]  <= '0;
        m_rawb[i] <= '0;
      end
    end else begin
      e_seg  <= all_seg(k);
      e_scan <= ~dig_pat((k / SD) % ND, k);
      e_an   <= ~(6'b000001 << ((k / SD) % ND));
      k      <= k + 1;
      if (bus.chipselect && !bus.write_n)
        case (bus.address)
          3'd0:
            for (int i = 0; i < ND; i++)
              m_dig[i] <= bus.writedata[4*i +: 4];
          3'd1: begin
            m_en    <= bus.writedata[0];
            m_blank <= bus.writedata[13:8];
            m_blink <= bus.writedata[21:16];
            m_raw   <= bus.writedata[29:24];
          end
          3'd2:
            for (int i = 0; i < 4; i++)
              m_rawb[i] <= bus.writedata[8*i +: 7];
          3'd3:
            for (int i = 0; i < 2; i++)
              m_rawb[4+i] <= bus.writedata[8*i +: 7];
          default: ;
        endcase
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    @(posedge clk); #1;
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a,
                    input logic [31:0] exp,
                    input string nm);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    check(nm, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  function automatic int an_idx(logic [ND-1:0] an);
    for (int i = 0; i < ND; i++)
      if (!an[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] status_exp(int kk);
    logic [31:0] s;
    s = '0;
    s[2:0] = 3'((kk / SD) % ND);
    s[8]   = ((kk / BD) % 2) == 1;
    return s;
  endfunction

  logic [7*ND-1:0] lit;
  logic [ND-1:0]   cur;
  int cnt, n_off, n_on, bad;
  bit found;

  initial begin
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    lit = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          check("seg_out",  seg_out,  e_seg);
          check("scan_seg", scan_seg, e_scan);
          check("scan_an",  scan_an,  e_an);
        end
      end
    join_none

    // reset state
    #12;
    check("rst_seg", seg_out, {7*ND{1'b1}});
    check("rst_an", scan_an, 6'b111110);
    check("rst_scan", scan_seg, 7'h7F);
    rd(3'd1, 32'h0, "rst_ctrl");
    rd(3'd0, 32'h0, "rst_digits");
    rd(3'd4, 32'h0, "rst_status");
    @(negedge clk);
    reset_n = 1'b1;

    // hex decode and one-cycle output latency
    wr(3'd0, 32'h0054_3210);
    rd(3'd0, 32'h0054_3210, "rb_digits");
    wr(3'd1, 32'h0000_0001);
    check("lat_old", seg_out, {7*ND{1'b1}});
    @(posedge clk); #1;
    check("hex_lit", seg_out, lit);

    // raw mode then blank on digit 0
    wr(3'd2, 32'h0000_0049);
    rd(3'd2, 32'h0000_0049, "rb_rawlo");
    wr(3'd1, 32'h0100_0001);
    @(posedge clk); #1;
    check("raw_d0", seg_out, {lit[7*ND-1:7], 7'h36});
    wr(3'd1, 32'h0100_0101);
    @(posedge clk); #1;
    check("blank_d0", seg_out, {lit[7*ND-1:7], 7'h7F});
    rd(3'd1, 32'h0100_0101, "rb_ctrl");

    // absent digits and reserved bits read 0
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, 32'h3F3F_3F01, "ctrl_mask");
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, 32'h7F7F_7F7F, "rawlo_mask");
    wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd3, 32'h0000_7F7F, "rawhi_mask");
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h00FF_FFFF, "digits_mask");
    wr(3'd0, 32'h0054_3210);

    // CTRL writes at varied alignment to scan/blink wraps
    for (int j = 0; j < 8; j++) begin
      wr(3'd1, 32'h0000_0001 | (32'(j * 9 % 64) << 8)
                             | (32'(j) << 16));
      repeat (j % 3) @(posedge clk);
    end
    wr(3'd1, 32'h0000_0001);

    // scan: each digit held SD cycles, index wraps 5->0
    cur = scan_an;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (scan_an != cur) found = 1'b1;
    end
    check("scan_start", found, 1'b1);
    for (int r = 0; r < 8; r++) begin
      cur = scan_an;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (scan_an == cur && cnt < 20);
      check("scan_hold", cnt, 4);
      check("scan_next", an_idx(scan_an), (an_idx(cur) + 1) % ND);
    end
    for (int r = 0; r < 12; r++) begin
      @(posedge clk); #2;
      rd(3'd4, status_exp(k), "status");
    end

    // blink digit 2 only
    wr(3'd1, 32'h0004_0001);
    @(posedge clk);
    n_off = 0; n_on = 0; bad = 0;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      if (seg_out[20:14] == 7'h7F) n_off++;
      if (seg_out[20:14] == 7'h24) n_on++;
      if (seg_out[13:7] != 7'h79) bad++;
    end
    check("blink_off", n_off, 16);
    check("blink_on", n_on, 16);
    check("blink_other", bad, 0);

    // asynchronous reset at scan index 3
    wr(3'd1, 32'h0000_0001);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (scan_an == 6'b110111) found = 1'b1;
    end
    check("wait_idx3", found, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_seg", seg_out, {7*ND{1'b1}});
    check("arst_an", scan_an, 6'b111110);
    check("arst_scan", scan_seg, 7'h7F);
    rd(3'd4, 32'h0, "arst_status");
    rd(3'd1, 32'h0, "arst_ctrl");
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (scan_an == 6'b111110 && cnt < 20);
    check("restart_first", cnt, 5);

    // read-only and unmapped writes change nothing
    wr(3'd0, 32'h0000_0A5C);
    wr(3'd1, 32'h0002_0001);
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, 32'h0000_0A5C, "ro_digits");
    rd(3'd1, 32'h0002_0001, "ro_ctrl");
    rd(3'd2, 32'h0, "ro_rawlo");
    rd(3'd3, 32'h0, "ro_rawhi");
    rd(3'd6, 32'h0, "ro_unmapped");
    @(posedge clk); #2;
    rd(3'd4, status_exp(k), "ro_status");
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

- Avalon-MM slave that drives up to eight 7-segment digits.
- Successor to the single-digit, 7-bit raw PIO:
  - parametrised digit count;
  - per-digit hex decode or raw segment mode;
  - blanking and blink;
  - configurable segment polarity;
  - both static per-digit outputs and a time-multiplexed scan output for shared-bus displays.
- Sits on the platform interconnect next to the other PIOs, is written by software, and drives board display pins directly.

## Interface

Parameters:
- NUM_DIGITS, 6, digits driven; legal 1..8
- SCAN_DIV, 50000, clk cycles per digit slot in scan mode; ≥2
- BLINK_DIV, 12500000, clk cycles per blink half-period; ≥2
- SEG_ACTIVE_LOW, 1, 1 = segment lit when output is 0

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- seg_out  out  7*NUM_DIGITS  static segments; digit i at bits [7i+6:7i], bit0 = a … bit6 = g
- scan_seg  out  7  multiplexed segments for the currently selected digit
- scan_an  out  NUM_DIGITS  one-hot digit select; active level follows SEG_ACTIVE_LOW

## Operation

Register map. A write occurs when chipselect && !write_n.
- 0 DIGITS: nibble i = [4i+3:4i] is the hex value of digit i. Bits for absent digits are ignored and read 0.
- 1 CTRL:
  - bit0 ENABLE
  - [15:8] BLANK mask
  - [23:16] BLINK mask
  - [31:24] RAW mask
- 2 RAW_LO: byte i holds the raw pattern [6:0] for digits 0–3; bit7 of each byte reads 0.
- 3 RAW_HI: same layout for digits 4–7.
- 4 STATUS: read-only. [2:0] scan index, bit8 blink phase. Writes are ignored.
- 5–7: read 0, writes ignored.
- Mask bits for digits ≥ NUM_DIGITS read 0.

Per-digit pattern (active-high) is selected in priority order:
- ENABLE=0 → 0.
- BLANK[i] → 0.
- BLINK[i] && phase=1 → 0.
- RAW[i] → raw pattern.
- Otherwise hex decode of nibble i.

Hex decode (gfedcba), 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

Polarity: SEG_ACTIVE_LOW=1 inverts every segment and scan_an output.

Scan tick generator:
- Counts 0..SCAN_DIV-1; wrap pulses the tick.
- On a tick, the index increments modulo NUM_DIGITS.
- With NUM_DIGITS=1 the index stays 0.

Blink tick generator:
- Counts 0..BLINK_DIV-1; wrap toggles the phase.

Both generators free-run regardless of ENABLE.

## Timing

Reset values:
- All registers 0.
- Counters 0, scan index 0, blink phase 0.
- Outputs:
  - seg_out, scan_seg: all segments unlit (all 1s when active-low).
  - scan_an: digit 0 selected.
  - readdata: 0.

Latency:
- Write at edge N: the register updates at N, and readdata reflects it immediately after N.
- seg_out, scan_seg and scan_an are registered and reflect the write after edge N+1.

Scan timing:
- The index advances on the edge where the counter wraps.
- scan_an and scan_seg change together on the following edge; each digit is held exactly SCAN_DIV cycles.
- scan_seg always matches seg_out of the selected digit in the same cycle.

Blink timing:
- The phase toggles every BLINK_DIV cycles; the first toggle occurs at cycle BLINK_DIV after reset release.

Boundary conditions:
- A CTRL write in the same cycle as a scan or blink wrap: both take effect. The output on edge N+1 uses the new mask and the new index/phase.
- Reset asserted mid-scan or mid-blink: everything returns to reset values asynchronously, and restarts from count 0 after release.
- A write to an unmapped or read-only address leaves all state unchanged.

## Structure

- Package seg7_pkg holds:
  - register address constants;
  - CTRL field offsets;
  - the hex-to-segment decode function and its 16-entry constant table.
- Sub-module seg7_tick_gen (parameter DIV; outputs a one-cycle tick on wrap) is instantiated twice, once for scan and once for blink.
- The top level contains:
  - register file;
  - per-digit pattern mux;
  - scan index and output registers.

## Test plan

- Reset with NUM_DIGITS=6, SEG_ACTIVE_LOW=1:
  - seg_out = all 1s, scan_an = 6'b111110.
  - Reading CTRL, DIGITS and STATUS returns 0.
- Write DIGITS=0x00543210 and CTRL=1:
  - seg_out digits 0..5 = ~{3F,06,5B,4F,66,6D}.
  - readback of DIGITS matches.
  - change is visible one cycle after the write.
- CTRL=0x0100_0001 (RAW[0]) with RAW_LO=0x49 → digit 0 = ~0x49, other digits unchanged. Then BLANK[0]=1 → digit 0 all 1s.
- SCAN_DIV=4:
  - scan_an steps 0→5→0, each digit held exactly 4 cycles.
  - scan_seg equals the selected digit's seg_out every cycle.
  - STATUS[2:0] tracks the index.
- BLINK_DIV=8, BLINK[2]=1: digit 2 alternates lit/unlit every 8 cycles while other digits stay lit.
- Assert reset_n mid-scan at index 3 → asynchronous return to index 0 and unlit outputs. Writes to address 4 and 6 change nothing.
